// File: rtl/conv_enc.sv
// conv_enc: framed rate-1/2 convolutional encoder with zero-tail termination.
// Define CONV_ENC_ERR_INJ_EN to XOR err_mask into each emitted symbol.
module conv_enc #(
   parameter int             K         = 4,
   parameter logic [K-1:0]   G0        = 4'b1111,
   parameter logic [K-1:0]   G1        = 4'b1101,
   parameter int             FRAME_LEN = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] out_pair,
   output logic       out_last,
   input  logic       out_ready,
   input  logic [1:0] err_mask,
   output logic       busy
);

   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_LEN - 1);
   localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_TAIL
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [K-2:0]    st_q, st_d;
   logic            ov_q, ov_d;
   logic [1:0]      pair_q, pair_d;
   logic            last_q, last_d;

   logic            slot_free;
   logic            load;
   logic            u;
   logic [K-1:0]    v;
   logic [1:0]      par;
   logic [1:0]      sym;

   // Tail bits are forced to zero so the trellis ends in state 0.
   assign slot_free = !ov_q || out_ready;
   assign in_ready  = rst_n && (state_q != S_TAIL) && slot_free;
   assign load      = (in_valid && in_ready) ||
                      ((state_q == S_TAIL) && slot_free);
   assign u         = (state_q == S_TAIL) ? 1'b0 : in_bit;
   assign v         = {u, st_q};
   assign par       = {^(G1 & v), ^(G0 & v)};

`ifdef CONV_ENC_ERR_INJ_EN
   // Corruption touches only the emitted symbol, never the encoder memory.
   assign sym = par ^ err_mask;
`else
   logic unused_err;
   assign unused_err = ^err_mask;
   assign sym        = par;
`endif

   assign out_valid = ov_q;
   assign out_pair  = pair_q;
   assign out_last  = last_q;
   assign busy      = (state_q != S_IDLE);

   // Next-state: frame sequencing, shift register and output slot.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      st_d    = st_q;
      ov_d    = ov_q;
      pair_d  = pair_q;
      last_d  = last_q;
      if (ov_q && out_ready) begin
         ov_d = 1'b0;
      end
      if (load) begin
         st_d   = v[K-1:1];
         ov_d   = 1'b1;
         pair_d = sym;
         last_d = 1'b0;
         unique case (state_q)
            S_IDLE: begin
               cnt_d   = CW'(1);
               state_d = S_DATA;
               if (FRAME_LEN == 1) begin
                  cnt_d   = '0;
                  state_d = S_TAIL;
               end
            end
            S_DATA: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = S_TAIL;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_TAIL: begin
               if (tcnt_q == LAST_TAIL) begin
                  tcnt_d  = '0;
                  last_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers; reset drops any pending symbol.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tcnt_q  <= '0;
         st_q    <= '0;
         ov_q    <= 1'b0;
         pair_q  <= 2'b00;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         st_q    <= st_d;
         ov_q    <= ov_d;
         pair_q  <= pair_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_conv_enc.sv
// tb_conv_enc: random and directed stimulus for conv_enc.
// Convolution-sum reference model checked every cycle.
module tb_conv_enc;

   localparam int K  = 4;
   localparam int FL = 4;
   localparam int N  = FL + K - 1;
   localparam logic [K-1:0] G0 = 4'b1111;
   localparam logic [K-1:0] G1 = 4'b1101;
`ifdef CONV_ENC_ERR_INJ_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       out_ready = 1'b1;
   logic [1:0] err_mask = 2'b00;
   logic       in_ready;
   logic       out_valid;
   logic [1:0] out_pair;
   logic       out_last;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   conv_enc #(
      .K(K), .G0(G0), .G1(G1), .FRAME_LEN(FL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .out_valid(out_valid), .out_pair(out_pair),
      .out_last(out_last), .out_ready(out_ready),
      .err_mask(err_mask), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: position within frame plus the frame's bit history.
   int         m_pos = 0;
   logic       m_ov = 1'b0;
   logic [1:0] m_pair = 2'b00;
   logic       m_last = 1'b0;
   logic       m_bits [0:N-1];
   logic       m_free;

   function automatic logic [1:0] enc(int p);
      logic a0, a1, uu;
      a0 = 1'b0;
      a1 = 1'b0;
      for (int i = 0; i < K; i++) begin
         uu = (p - i >= 0) ? m_bits[p - i] : 1'b0;
         a0 = a0 ^ (G0[K-1-i] & uu);
         a1 = a1 ^ (G1[K-1-i] & uu);
      end
      return {a1, a0};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos  = 0;
         m_ov   = 1'b0;
         m_pair = 2'b00;
         m_last = 1'b0;
      end else begin
         m_free = !m_ov || out_ready;
         if ((in_valid && m_pos < FL && m_free) ||
             (m_pos >= FL && m_free)) begin
            m_bits[m_pos] = (m_pos < FL) ? in_bit : 1'b0;
            m_pair = enc(m_pos) ^ (ERR ? err_mask : 2'b00);
            m_last = (m_pos == N - 1);
            m_pos  = m_last ? 0 : m_pos + 1;
            m_ov   = 1'b1;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   logic       col_en = 1'b0;
   int         col_n = 0;
   logic [1:0] col_p [0:15];
   logic       col_l [0:15];
   logic       col_b [0:15];

   task automatic compare();
      logic exp_rdy;
      exp_rdy = rst_n && (m_pos < FL) && (!m_ov || out_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, m_ov);
      chk("busy", busy, m_pos != 0);
      if (m_ov) begin
         chk("out_pair", out_pair, m_pair);
         chk("out_last", out_last, m_last);
      end
      if (!rst_n) begin
         chk("rst_pair", out_pair, 2'b00);
         chk("rst_last", out_last, 1'b0);
      end
   endtask

   // One cycle: check at the falling edge, return 2 units past rising edge.
   task automatic cyc();
      @(negedge clk);
      compare();
      if (col_en && out_valid && out_ready && col_n < 16) begin
         col_p[col_n] = out_pair;
         col_l[col_n] = out_last;
         col_b[col_n] = busy;
         col_n++;
      end
      @(posedge clk);
      #2;
   endtask

   logic [1:0] imp [0:6];
   logic [3:0] pat;
   int         lows;
   bit         hit;

   initial begin
      imp[0] = ERR ? 2'b01 : 2'b11;
      imp[1] = 2'b11;
      imp[2] = 2'b01;
      imp[3] = 2'b11;
      imp[4] = 2'b00;
      imp[5] = 2'b00;
      imp[6] = 2'b00;

      #1;
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_pair", out_pair, 2'b00);
      chk("reset_last", out_last, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_ready", in_ready, 1'b0);
      cyc();
      cyc();
      rst_n = 1'b1;

      // impulse 1,0,0,0 with mask on the first symbol only
      col_en   = 1'b1;
      in_valid = 1'b1;
      in_bit   = 1'b1;
      err_mask = 2'b10;
      cyc();
      err_mask = 2'b00;
      in_bit   = 1'b0;
      repeat (3) cyc();
      in_valid = 1'b0;
      repeat (8) cyc();
      col_en = 1'b0;
      chk("imp_count", col_n, 7);
      for (int i = 0; i < 7; i++) begin
         chk("imp_sym", col_p[i], imp[i]);
         chk("imp_last", col_l[i], i == 6);
      end
      chk("imp_busy_before_last", col_b[5], 1'b1);
      chk("imp_busy_at_last", col_b[6], 1'b0);

      // back-to-back frames with identical data
      pat      = 4'b1011;
      lows     = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 3 * N; c++) begin
         in_bit = (m_pos < FL) ? pat[m_pos] : 1'b0;
         #1;
         if (!in_ready) lows++;
         cyc();
      end
      in_valid = 1'b0;
      chk("b2b_ready_low_cycles", lows, 3 * (K - 1));

      // backpressure mid-frame
      in_valid = 1'b1;
      repeat (2) begin
         in_bit = 1'($urandom);
         cyc();
      end
      out_ready = 1'b0;
      repeat (5) begin
         in_bit = 1'($urandom);
         #1;
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_out_valid", out_valid, 1'b1);
         cyc();
      end
      out_ready = 1'b1;
      repeat (15) begin
         in_bit = 1'($urandom);
         cyc();
      end
      in_valid = 1'b0;
      repeat (10) cyc();

      // async reset while the second tail symbol is showing
      in_valid = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 60 && !hit; c++) begin
         if (m_pos == FL + 2) hit = 1'b1;
         else begin
            in_bit = 1'($urandom);
            cyc();
         end
      end
      chk("reach_tail2", hit, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_pair", out_pair, 2'b00);
      chk("arst_last", out_last, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_ready", in_ready, 1'b0);
      cyc();
      rst_n  = 1'b1;
      in_bit = 1'b1;
      cyc();
      chk("post_rst_valid", out_valid, 1'b1);
      chk("post_rst_pair", out_pair, 2'b11);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_bit    = 1'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         err_mask  = 2'($urandom);
         cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (20) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
